// File: rtl/bcd_pkg.sv
// Shared definitions for the multi-digit BCD counter: digit type, bounds and
// the nibble clamp applied on parallel load.
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Non-decimal nibbles (A-F) saturate to 9.
    function automatic bcd_digit_t bcd_clamp(input logic [BCD_W-1:0] n);
        return (n > BCD_MAX) ? BCD_MAX : bcd_digit_t'(n);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade stage: synchronous reset, clamped parallel load, and a single
// up/down step when enabled by the top-level carry/borrow chain.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  bcd_digit_t load_d,
    input  logic       step,
    input  logic       up,
    output bcd_digit_t q,
    output logic       at_max,
    output logic       at_min
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= bcd_clamp(load_d);
        end else if (step) begin
            if (up) begin
                q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            end else begin
                q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
            end
        end
    end

    assign at_max = (q == BCD_MAX);
    assign at_min = (q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// DIGITS-digit BCD up/down counter with load and combinational terminal count.
// Define BCD_COUNTER_SAT_EN to saturate at the bounds instead of wrapping.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc
);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] step;
    logic              all_max;
    logic              all_min;
    logic              at_bound;
    logic              sat_hold;
    logic              adv;

    assign all_max  = &at_max;
    assign all_min  = &at_min;
    assign at_bound = up ? all_max : all_min;

`ifdef BCD_COUNTER_SAT_EN
    assign sat_hold = at_bound;
`else
    assign sat_hold = 1'b0;
`endif

    assign adv = en & ~sat_hold;

    // Each digit's step is a prefix AND of lower stages, so the whole
    // carry/borrow chain resolves in one cycle without a feedback loop.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign step[gi] = adv;
            end else begin : g_upper
                assign step[gi] = adv & (up ? (&at_max[gi-1:0]) : (&at_min[gi-1:0]));
            end

            bcd_digit u_digit (
                .clk    (clk),
                .reset  (reset),
                .load   (load),
                .load_d (load_val[4*gi +: 4]),
                .step   (step[gi]),
                .up     (up),
                .q      (count[4*gi +: 4]),
                .at_max (at_max[gi]),
                .at_min (at_min[gi])
            );
        end
    endgenerate

    assign tc = en & ~load & ~reset & at_bound;

endmodule
